sprite_motion_engine: RTL and testbench

Per-frame physics stage directly upstream of VGA_driver. Owns position and velocity state for the sprites and produces the sprite_row/sprite_col buses the driver consumes. On each frame_start pulse it steps every sprite by its velocity, applies gravity, reflects off the screen edges, then commits all new positions atomically so the driver never sees a half-updated frame.

---
 rtl/sprite_motion_engine.sv | 209 ++++++++++++++++++++
 tb/tb_sprite_motion_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: per-frame sprite physics feeding the VGA driver.
// Each accepted frame_start walks the sprites one at a time (CALC then WB),
// updating shadow copies of position and velocity, and a final COMMIT copies
// every shadow position to the output buses on one edge so the driver never
// sees a mix of old and new positions.
module sprite_motion_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SCREEN_W    = 1600,
    parameter int SCREEN_H    = 1200,
    parameter int SPRITE_SIZE = 127,
    parameter int GRAVITY     = 1,
    parameter int VEL_W       = 8
) (
    input  logic                             clock_162,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic                             pause,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [$clog2(NUM_SPRITES)-1:0]   load_idx,
    input  logic [10:0]                      load_row,
    input  logic [11:0]                      load_col,
    input  logic signed [VEL_W-1:0]          load_vrow,
    input  logic signed [VEL_W-1:0]          load_vcol,
    output logic [NUM_SPRITES*11-1:0]        sprite_row,
    output logic [NUM_SPRITES*12-1:0]        sprite_col,
    output logic                             busy,
    output logic                             update_done,
    output logic                             overrun
);

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int ROW_MAX_I = SCREEN_H - SPRITE_SIZE;
    localparam int COL_MAX_I = SCREEN_W - SPRITE_SIZE;

    localparam logic [10:0]        ROW_MAX    = 11'(ROW_MAX_I);
    localparam logic [11:0]        COL_MAX    = 12'(COL_MAX_I);
    localparam logic signed [12:0] ROW_MAX_S  = 13'(ROW_MAX_I);
    localparam logic signed [12:0] COL_MAX_S  = 13'(COL_MAX_I);
    localparam logic signed [12:0] ROW_MAX2_S = 13'(2 * ROW_MAX_I);
    localparam logic signed [12:0] COL_MAX2_S = 13'(2 * COL_MAX_I);

    localparam logic signed [VEL_W-1:0] VEL_HI  = VEL_W'(2**(VEL_W-1) - 1);
    localparam logic signed [VEL_W-1:0] VEL_LO  = VEL_W'(1 - 2**(VEL_W-1));
    localparam logic signed [VEL_W-1:0] VEL_BAD = {1'b1, {(VEL_W-1){1'b0}}};
    // Two guard bits so velocity plus gravity cannot wrap before saturation.
    localparam logic signed [VEL_W+1:0] GRAV_W   = (VEL_W+2)'(GRAVITY);
    localparam logic signed [VEL_W+1:0] VEL_HI_W = (VEL_W+2)'(2**(VEL_W-1) - 1);
    localparam logic signed [VEL_W+1:0] VEL_LO_W = (VEL_W+2)'(1 - 2**(VEL_W-1));
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, CALC, WB, COMMIT} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;

    logic [10:0]             shadow_row_reg [NUM_SPRITES];
    logic [11:0]             shadow_col_reg [NUM_SPRITES];
    logic [10:0]             out_row_reg    [NUM_SPRITES];
    logic [11:0]             out_col_reg    [NUM_SPRITES];
    logic signed [VEL_W-1:0] vrow_reg       [NUM_SPRITES];
    logic signed [VEL_W-1:0] vcol_reg       [NUM_SPRITES];

    logic signed [12:0] next_row_reg, next_col_reg;
    logic               update_done_reg, overrun_reg;

    logic signed [12:0]      refl_row, refl_col;
    logic signed [VEL_W-1:0] vrow_cur, vcol_cur, refl_vrow, refl_vcol, grav_vrow;
    logic signed [VEL_W+1:0] vsum;
    logic                    load_fire;
    logic                    unused_refl_bits;

    assign load_ready = (state_reg == IDLE) && !frame_start;
    assign load_fire  = load_valid && load_ready;
    assign busy        = (state_reg != IDLE);
    assign update_done = update_done_reg;
    assign overrun     = overrun_reg;

    // Reflected positions always land in 0..MAX, so the top bits are never needed.
    assign unused_refl_bits = ^{refl_row[12:11], refl_col[12]};

    // State and sprite-index register.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic: walk CALC/WB per sprite, then COMMIT once.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start && !pause) begin
                    state_next = CALC;
                    idx_next   = '0;
                end
            end
            CALC: state_next = WB;
            WB: begin
                if (idx_reg == IDX_LAST) begin
                    state_next = COMMIT;
                end else begin
                    state_next = CALC;
                    idx_next   = idx_reg + 1'b1;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edge reflection on both axes, then saturating gravity on the row velocity.
    always_comb begin
        vrow_cur  = vrow_reg[idx_reg];
        vcol_cur  = vcol_reg[idx_reg];
        refl_row  = next_row_reg;
        refl_vrow = vrow_cur;
        refl_col  = next_col_reg;
        refl_vcol = vcol_cur;
        if (next_row_reg < 13'sd0) begin
            refl_row  = -next_row_reg;
            refl_vrow = -vrow_cur;
        end else if (next_row_reg > ROW_MAX_S) begin
            refl_row  = ROW_MAX2_S - next_row_reg;
            refl_vrow = -vrow_cur;
        end
        if (next_col_reg < 13'sd0) begin
            refl_col  = -next_col_reg;
            refl_vcol = -vcol_cur;
        end else if (next_col_reg > COL_MAX_S) begin
            refl_col  = COL_MAX2_S - next_col_reg;
            refl_vcol = -vcol_cur;
        end
        vsum      = $signed({{2{refl_vrow[VEL_W-1]}}, refl_vrow}) + GRAV_W;
        grav_vrow = vsum[VEL_W-1:0];
        if (vsum > VEL_HI_W) begin
            grav_vrow = VEL_HI;
        end else if (vsum < VEL_LO_W) begin
            grav_vrow = VEL_LO;
        end
    end

    // Sprite state: loads, per-sprite step, write-back and atomic commit.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_row_reg[i] <= ((i & 2) != 0) ? ROW_MAX : 11'd0;
                shadow_col_reg[i] <= ((i & 1) != 0) ? COL_MAX : 12'd0;
                out_row_reg[i]    <= ((i & 2) != 0) ? ROW_MAX : 11'd0;
                out_col_reg[i]    <= ((i & 1) != 0) ? COL_MAX : 12'd0;
                vrow_reg[i]       <= '0;
                vcol_reg[i]       <= '0;
            end
            next_row_reg    <= '0;
            next_col_reg    <= '0;
            update_done_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            update_done_reg <= (state_reg == COMMIT);
            if (frame_start && !pause && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (load_fire) begin
                        shadow_row_reg[load_idx] <= (load_row > ROW_MAX) ? ROW_MAX : load_row;
                        shadow_col_reg[load_idx] <= (load_col > COL_MAX) ? COL_MAX : load_col;
                        out_row_reg[load_idx]    <= (load_row > ROW_MAX) ? ROW_MAX : load_row;
                        out_col_reg[load_idx]    <= (load_col > COL_MAX) ? COL_MAX : load_col;
                        vrow_reg[load_idx]       <= (load_vrow == VEL_BAD) ? VEL_LO : load_vrow;
                        vcol_reg[load_idx]       <= (load_vcol == VEL_BAD) ? VEL_LO : load_vcol;
                    end
                end
                CALC: begin
                    next_row_reg <= $signed({2'b00, shadow_row_reg[idx_reg]})
                                  + $signed({{(13-VEL_W){vrow_cur[VEL_W-1]}}, vrow_cur});
                    next_col_reg <= $signed({1'b0, shadow_col_reg[idx_reg]})
                                  + $signed({{(13-VEL_W){vcol_cur[VEL_W-1]}}, vcol_cur});
                end
                WB: begin
                    shadow_row_reg[idx_reg] <= refl_row[10:0];
                    shadow_col_reg[idx_reg] <= refl_col[11:0];
                    vrow_reg[idx_reg]       <= grav_vrow;
                    vcol_reg[idx_reg]       <= refl_vcol;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        out_row_reg[i] <= shadow_row_reg[i];
                        out_col_reg[i] <= shadow_col_reg[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack committed positions onto the driver buses, sprite 0 in the low bits.
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_pack
        assign sprite_row[gi*11 +: 11] = out_row_reg[gi];
        assign sprite_col[gi*12 +: 12] = out_col_reg[gi];
    end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// tb_sprite_motion_engine: directed scenarios plus random traffic, checked
// every cycle against a frame-level physics model kept in plain integers.
module tb_sprite_motion_engine;
    localparam int NS   = 4;
    localparam int G    = 1;
    localparam int RMAX = 1073;
    localparam int CMAX = 1473;
    localparam int LAT  = 2 * NS + 1;

    logic               clock_162 = 1'b0;
    logic               rst = 1'b1, frame_start = 1'b0, pause = 1'b0, load_valid = 1'b0;
    logic               load_ready;
    logic [1:0]         load_idx = '0;
    logic [10:0]        load_row = '0;
    logic [11:0]        load_col = '0;
    logic signed [7:0]  load_vrow = '0, load_vcol = '0;
    logic [NS*11-1:0]   sprite_row;
    logic [NS*12-1:0]   sprite_col;
    logic               busy, update_done, overrun;

    always #5 clock_162 = ~clock_162;

    sprite_motion_engine #(.GRAVITY(G)) dut (
        .clock_162(clock_162), .rst(rst), .frame_start(frame_start), .pause(pause),
        .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
        .load_row(load_row), .load_col(load_col), .load_vrow(load_vrow), .load_vcol(load_vcol),
        .sprite_row(sprite_row), .sprite_col(sprite_col), .busy(busy),
        .update_done(update_done), .overrun(overrun)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int m_row[NS], m_col[NS], m_vr[NS], m_vc[NS], p_row[NS], p_col[NS];
    int timer = 0;
    bit m_done = 0, m_ovr = 0, chk_en = 0;

    function automatic int refl_pos(int nxt, int mx);
        if (nxt < 0) return -nxt;
        if (nxt > mx) return 2 * mx - nxt;
        return nxt;
    endfunction

    function automatic int refl_vel(int nxt, int mx, int v);
        return (nxt < 0 || nxt > mx) ? -v : v;
    endfunction

    function automatic int sat(int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cycle %0d: got %0d, want %0d", name, idx, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_row[i] = ((i & 2) != 0) ? RMAX : 0;
            m_col[i] = ((i & 1) != 0) ? CMAX : 0;
            m_vr[i] = 0;
            m_vc[i] = 0;
        end
        timer = 0;
        m_done = 0;
        m_ovr = 0;
    endtask

    // Reference model: whole-frame physics at acceptance, visible LAT edges later.
    always @(posedge clock_162) begin
        cyc++;
        if (rst) begin
            model_reset();
            chk_en = 1;
        end else begin
            m_done = 0;
            if (timer != 0) begin
                if (frame_start && !pause) m_ovr = 1;
                if (timer == LAT) begin
                    for (int i = 0; i < NS; i++) begin
                        m_row[i] = p_row[i];
                        m_col[i] = p_col[i];
                    end
                    m_done = 1;
                    timer = 0;
                end else begin
                    timer++;
                end
            end else if (frame_start && !pause) begin
                for (int i = 0; i < NS; i++) begin
                    int nr, nc;
                    nr = m_row[i] + m_vr[i];
                    nc = m_col[i] + m_vc[i];
                    p_row[i] = refl_pos(nr, RMAX);
                    m_vr[i]  = sat(refl_vel(nr, RMAX, m_vr[i]) + G);
                    p_col[i] = refl_pos(nc, CMAX);
                    m_vc[i]  = refl_vel(nc, CMAX, m_vc[i]);
                end
                timer = 1;
            end else if (load_valid && !frame_start) begin
                int i;
                i = int'(load_idx);
                m_row[i] = (int'(load_row) > RMAX) ? RMAX : int'(load_row);
                m_col[i] = (int'(load_col) > CMAX) ? CMAX : int'(load_col);
                m_vr[i]  = (int'(load_vrow) == -128) ? -127 : int'(load_vrow);
                m_vc[i]  = (int'(load_vcol) == -128) ? -127 : int'(load_vcol);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock_162) begin
        if (chk_en) begin
            for (int i = 0; i < NS; i++) begin
                chk("sprite_row", i, int'(sprite_row[i*11 +: 11]), m_row[i]);
                chk("sprite_col", i, int'(sprite_col[i*12 +: 12]), m_col[i]);
            end
            chk("busy", 0, int'(busy), int'(timer != 0));
            chk("update_done", 0, int'(update_done), int'(m_done));
            chk("overrun", 0, int'(overrun), int'(m_ovr));
            chk("load_ready", 0, int'(load_ready), int'(timer == 0 && !frame_start));
        end
    end

    task automatic tick();
        @(posedge clock_162);
        #1;
    endtask

    task automatic set_load(int idx, int r, int c, int vr, int vc);
        load_idx = 2'(idx); load_row = 11'(r); load_col = 12'(c);
        load_vrow = 8'(vr); load_vcol = 8'(vc);
        load_valid = 1'b1;
        $display("load idx=%0d row=%0d col=%0d vrow=%0d vcol=%0d", idx, r, c, vr, vc);
    endtask

    // Holds load_valid until the engine takes it, bounded to 50 cycles.
    task automatic accept_load();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock_162);
            if (load_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("load_accept_timeout", 0, 0, 1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_load(int idx, int r, int c, int vr, int vc);
        set_load(idx, r, c, vr, vc);
        accept_load();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        $display("frame pause=%0d", pause);
    endtask

    task automatic frame_and_wait();
        pulse_frame();
        repeat (LAT + 1) tick();
        @(negedge clock_162);
        #1;
    endtask

    function automatic int row_of(int i);
        return int'(sprite_row[i*11 +: 11]);
    endfunction

    function automatic int col_of(int i);
        return int'(sprite_col[i*12 +: 12]);
    endfunction

    initial begin
        repeat (3) tick();
        @(negedge clock_162);
        chk("lit_rst_row", 3, row_of(3), 1073);
        chk("lit_rst_col", 1, col_of(1), 1473);
        chk("lit_rst_row", 0, row_of(0), 0);
        rst = 1'b0;
        tick();

        // Free motion.
        do_load(0, 0, 0, 5, 3);
        frame_and_wait();
        chk("lit_free_row", 0, row_of(0), 5);
        chk("lit_free_col", 0, col_of(0), 3);
        chk("lit_free_col", 1, col_of(1), 1473);

        // Right-wall bounce.
        do_load(1, 500, 1470, 0, 10);
        frame_and_wait();
        chk("lit_wall_col", 1, col_of(1), 1466);
        frame_and_wait();
        chk("lit_wall_col2", 1, col_of(1), 1456);

        // Top-wall bounce with gravity.
        do_load(2, 2, 100, -5, 0);
        frame_and_wait();
        chk("lit_top_row", 2, row_of(2), 3);
        frame_and_wait();
        chk("lit_top_row2", 2, row_of(2), 9);

        // Velocity saturation.
        do_load(3, 0, 200, 127, 0);
        frame_and_wait();
        chk("lit_sat_row", 3, row_of(3), 127);
        frame_and_wait();
        chk("lit_sat_row2", 3, row_of(3), 254);

        // Load clamping, including the -128 velocity.
        do_load(0, 1200, 4000, -128, 0);
        @(negedge clock_162);
        chk("lit_clamp_row", 0, row_of(0), 1073);
        chk("lit_clamp_col", 0, col_of(0), 1473);
        tick();
        frame_and_wait();
        chk("lit_clamp_vel", 0, row_of(0), 946);

        // Pause suppresses the frame.
        pause = 1'b1;
        pulse_frame();
        @(negedge clock_162);
        chk("lit_pause_busy", 0, int'(busy), 0);
        pause = 1'b0;
        tick();

        // Load requested while busy waits for IDLE.
        pulse_frame();
        set_load(1, 600, 700, 1, 1);
        @(negedge clock_162);
        chk("lit_ready_busy", 0, int'(load_ready), 0);
        accept_load();
        @(negedge clock_162);
        chk("lit_late_load", 1, row_of(1), 600);
        tick();

        // Load and frame_start together: frame wins.
        set_load(2, 10, 20, 0, 0);
        frame_start = 1'b1;
        @(negedge clock_162);
        chk("lit_ready_fs", 0, int'(load_ready), 0);
        tick();
        frame_start = 1'b0;
        @(negedge clock_162);
        chk("lit_fs_busy", 0, int'(busy), 1);
        accept_load();
        @(negedge clock_162);
        chk("lit_fs_load", 2, row_of(2), 10);
        tick();

        // Overrun: second frame 3 cycles into an update.
        pulse_frame();
        repeat (2) tick();
        pulse_frame();
        repeat (LAT + 2) tick();
        @(negedge clock_162);
        chk("lit_overrun", 0, int'(overrun), 1);
        tick();

        // Reset during WB of sprite 2.
        pulse_frame();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        @(negedge clock_162);
        chk("lit_rst_mid_busy", 0, int'(busy), 0);
        chk("lit_rst_mid_done", 0, int'(update_done), 0);
        chk("lit_rst_mid_row", 0, row_of(0), 0);
        chk("lit_rst_mid_ovr", 0, int'(overrun), 0);
        rst = 1'b0;
        tick();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst = (r < 2);
            frame_start = (r >= 2 && r < 10);
            pause = ($urandom_range(0, 3) == 0);
            load_valid = ($urandom_range(0, 2) == 0);
            load_idx = 2'($urandom_range(0, 3));
            load_row = 11'($urandom);
            load_col = 12'($urandom);
            load_vrow = 8'($urandom);
            load_vcol = 8'($urandom);
            if (frame_start) $display("rand frame pause=%0d", pause);
            tick();
        end
        rst = 1'b0; frame_start = 1'b0; pause = 1'b0; load_valid = 1'b0;
        repeat (LAT + 3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
